// File: rtl/alu_iter_md_if.sv
// Issue/result handshake bundle between operand forwarding, alu_iter_md and writeback.
interface alu_iter_md_if #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN),
    parameter int TAG_W   = 5
);
    logic               in_valid;
    logic               in_ready;
    logic [4:0]         op;
    logic [XLEN-1:0]    a;
    logic [XLEN-1:0]    b;
    logic [SHAMT_W-1:0] shamt;
    logic [TAG_W-1:0]   tag_in;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [XLEN-1:0]    result;
    logic [TAG_W-1:0]   tag_out;
    logic               busy;

    modport master (
        output in_valid, op, a, b, shamt, tag_in, flush, out_ready,
        input  in_ready, out_valid, result, tag_out, busy
    );

    modport slave (
        input  in_valid, op, a, b, shamt, tag_in, flush, out_ready,
        output in_ready, out_valid, result, tag_out, busy
    );
endinterface

// File: rtl/alu_iter_md.sv
// Execute-stage ALU: registered single-cycle base ops plus iterative RV32M multiply/divide.
// Define ALU_FAST_MUL_EN to compute multiplies with a single-cycle 2*XLEN multiplier instead.
module alu_iter_md #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN),
    parameter int TAG_W   = 5
) (
    input  logic          clk,
    input  logic          rst,
    alu_iter_md_if.slave  bus
);
    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_SLT    = 5'd2;
    localparam logic [4:0] OP_SLTU   = 5'd3;
    localparam logic [4:0] OP_AND    = 5'd4;
    localparam logic [4:0] OP_OR     = 5'd5;
    localparam logic [4:0] OP_XOR    = 5'd6;
    localparam logic [4:0] OP_SLL    = 5'd7;
    localparam logic [4:0] OP_SRL    = 5'd8;
    localparam logic [4:0] OP_SRA    = 5'd9;
    localparam logic [4:0] OP_MUL    = 5'd10;
    localparam logic [4:0] OP_MULH   = 5'd11;
    localparam logic [4:0] OP_MULHSU = 5'd12;
    localparam logic [4:0] OP_MULHU  = 5'd13;
    localparam logic [4:0] OP_DIV    = 5'd14;
    localparam logic [4:0] OP_DIVU   = 5'd15;
    localparam logic [4:0] OP_REM    = 5'd16;
    localparam logic [4:0] OP_REMU   = 5'd17;

    localparam logic [XLEN-1:0]    ZERO     = {XLEN{1'b0}};
    localparam logic [XLEN-1:0]    ONE      = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]    ALL1     = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]    MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [SHAMT_W-1:0] CNT_ZERO = {SHAMT_W{1'b0}};
    localparam logic [SHAMT_W-1:0] CNT_ONE  = {{(SHAMT_W-1){1'b0}}, 1'b1};
    localparam logic [SHAMT_W-1:0] CNT_LAST = {SHAMT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic [XLEN-1:0] neg2(input logic [XLEN-1:0] x);
        return (~x) + ONE;
    endfunction

    state_t             state_r;
    state_t             state_nxt_s;
    logic [XLEN-1:0]    hi_r;
    logic [XLEN-1:0]    lo_r;
    logic [XLEN-1:0]    opnd_r;
    logic [SHAMT_W-1:0] cnt_r;
    logic               neg_r;
    logic               sel_hi_r;
    logic               is_div_r;
    logic               out_valid_r;
    logic [XLEN-1:0]    result_r;
    logic [TAG_W-1:0]   tag_out_r;

    logic               in_ready_s;
    logic               accept_s;
    logic               is_mul_op_s;
    logic               is_div_op_s;
    logic               div_zero_s;
    logic               div_ovf_s;
    logic               start_mul_s;
    logic               start_div_s;
    logic               load_base_s;
    logic               a_sgn_s;
    logic               b_sgn_s;
    logic               a_neg_s;
    logic               b_neg_s;
    logic [XLEN-1:0]    a_mag_s;
    logic [XLEN-1:0]    b_mag_s;
    logic               start_neg_s;
    logic               start_sel_hi_s;
    logic [XLEN:0]      mul_sum_s;
    logic [XLEN:0]      div_shift_s;
    logic [XLEN:0]      div_diff_s;
    logic [2*XLEN-1:0]  prod_fix_s;
    logic [XLEN-1:0]    div_sel_s;
    logic [XLEN-1:0]    done_res_s;
    logic [XLEN-1:0]    base_res_s;
`ifdef ALU_FAST_MUL_EN
    logic [2*XLEN-1:0]  fast_prod_s;
`endif

    assign in_ready_s  = (state_r == ST_IDLE) && !bus.flush && (!out_valid_r || bus.out_ready);
    assign accept_s    = bus.in_valid && in_ready_s;

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.result    = result_r;
    assign bus.tag_out   = tag_out_r;
    assign bus.busy      = (state_r != ST_IDLE);

    // Operation classification, operand signedness and iteration start decision.
    always_comb begin
        is_mul_op_s = (bus.op >= OP_MUL) && (bus.op <= OP_MULHU);
        is_div_op_s = (bus.op >= OP_DIV) && (bus.op <= OP_REMU);
        div_zero_s  = (bus.b == ZERO);
        div_ovf_s   = ((bus.op == OP_DIV) || (bus.op == OP_REM)) &&
                      (bus.a == MOST_NEG) && (bus.b == ALL1);
        a_sgn_s     = (bus.op == OP_MULH) || (bus.op == OP_MULHSU) ||
                      (bus.op == OP_DIV)  || (bus.op == OP_REM);
        b_sgn_s     = (bus.op == OP_MULH) || (bus.op == OP_DIV) || (bus.op == OP_REM);
        a_neg_s     = a_sgn_s && bus.a[XLEN-1];
        b_neg_s     = b_sgn_s && bus.b[XLEN-1];
        a_mag_s     = a_neg_s ? neg2(bus.a) : bus.a;
        b_mag_s     = b_neg_s ? neg2(bus.b) : bus.b;
        // A remainder follows the dividend; everything else follows the operand sign product.
        if ((bus.op == OP_REM) || (bus.op == OP_REMU)) begin
            start_neg_s    = a_neg_s;
            start_sel_hi_s = 1'b1;
        end else if (is_div_op_s) begin
            start_neg_s    = a_neg_s ^ b_neg_s;
            start_sel_hi_s = 1'b0;
        end else begin
            start_neg_s    = a_neg_s ^ b_neg_s;
            start_sel_hi_s = (bus.op != OP_MUL);
        end
`ifdef ALU_FAST_MUL_EN
        start_mul_s = 1'b0;
`else
        start_mul_s = accept_s && is_mul_op_s;
`endif
        start_div_s = accept_s && is_div_op_s && !div_zero_s && !div_ovf_s;
        load_base_s = accept_s && !start_mul_s && !start_div_s;
    end

    // Single-cycle results, including divide special cases resolved at accept.
    always_comb begin
`ifdef ALU_FAST_MUL_EN
        fast_prod_s = {{XLEN{a_neg_s}}, bus.a} * {{XLEN{b_neg_s}}, bus.b};
`endif
        base_res_s = ZERO;
        case (bus.op)
            OP_ADD:  base_res_s = bus.a + bus.b;
            OP_SUB:  base_res_s = bus.a - bus.b;
            OP_SLT:  base_res_s = {{(XLEN-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            OP_SLTU: base_res_s = {{(XLEN-1){1'b0}}, (bus.a < bus.b)};
            OP_AND:  base_res_s = bus.a & bus.b;
            OP_OR:   base_res_s = bus.a | bus.b;
            OP_XOR:  base_res_s = bus.a ^ bus.b;
            OP_SLL:  base_res_s = bus.a << bus.shamt;
            OP_SRL:  base_res_s = bus.a >> bus.shamt;
            OP_SRA:  base_res_s = $signed(bus.a) >>> bus.shamt;
`ifdef ALU_FAST_MUL_EN
            OP_MUL:  base_res_s = fast_prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:
                     base_res_s = fast_prod_s[2*XLEN-1:XLEN];
`endif
            OP_DIV, OP_DIVU: base_res_s = div_zero_s ? ALL1 : bus.a;
            OP_REM, OP_REMU: base_res_s = div_zero_s ? bus.a : ZERO;
            default: base_res_s = ZERO;
        endcase
    end

    // One shift-add / restoring-subtract step and the final sign correction.
    always_comb begin
        mul_sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opnd_r} : {(XLEN+1){1'b0}});
        div_shift_s = {hi_r, lo_r[XLEN-1]};
        div_diff_s  = div_shift_s - {1'b0, opnd_r};
        prod_fix_s  = neg_r ? ((~{hi_r, lo_r}) + {{(2*XLEN-1){1'b0}}, 1'b1}) : {hi_r, lo_r};
        div_sel_s   = sel_hi_r ? hi_r : lo_r;
        if (is_div_r) begin
            done_res_s = neg_r ? neg2(div_sel_s) : div_sel_s;
        end else if (sel_hi_r) begin
            done_res_s = prod_fix_s[2*XLEN-1:XLEN];
        end else begin
            done_res_s = prod_fix_s[XLEN-1:0];
        end
    end

    // Next-state logic; flush wins over everything.
    always_comb begin
        state_nxt_s = state_r;
        if (bus.flush) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_mul_s) begin
                        state_nxt_s = ST_MUL;
                    end else if (start_div_s) begin
                        state_nxt_s = ST_DIV;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (cnt_r == CNT_LAST) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                ST_DONE: state_nxt_s = ST_IDLE;
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Iteration datapath: hi/lo hold product or remainder/quotient, opnd the fixed operand.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_r     <= ZERO;
            lo_r     <= ZERO;
            opnd_r   <= ZERO;
            cnt_r    <= CNT_ZERO;
            neg_r    <= 1'b0;
            sel_hi_r <= 1'b0;
            is_div_r <= 1'b0;
        end else if (bus.flush) begin
            cnt_r <= CNT_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_mul_s || start_div_s) begin
                        hi_r     <= ZERO;
                        lo_r     <= start_mul_s ? b_mag_s : a_mag_s;
                        opnd_r   <= start_mul_s ? a_mag_s : b_mag_s;
                        cnt_r    <= CNT_ZERO;
                        neg_r    <= start_neg_s;
                        sel_hi_r <= start_sel_hi_s;
                        is_div_r <= start_div_s;
                    end
                end
                ST_MUL: begin
                    hi_r  <= mul_sum_s[XLEN:1];
                    lo_r  <= {mul_sum_s[0], lo_r[XLEN-1:1]};
                    cnt_r <= cnt_r + CNT_ONE;
                end
                ST_DIV: begin
                    if (!div_diff_s[XLEN]) begin
                        hi_r <= div_diff_s[XLEN-1:0];
                        lo_r <= {lo_r[XLEN-2:0], 1'b1};
                    end else begin
                        hi_r <= div_shift_s[XLEN-1:0];
                        lo_r <= {lo_r[XLEN-2:0], 1'b0};
                    end
                    cnt_r <= cnt_r + CNT_ONE;
                end
                default: cnt_r <= CNT_ZERO;
            endcase
        end
    end

    // Output slot: loads on a single-cycle accept or DONE, clears on handshake or flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            result_r    <= ZERO;
            tag_out_r   <= {TAG_W{1'b0}};
        end else if (bus.flush) begin
            out_valid_r <= 1'b0;
        end else begin
            if (load_base_s) begin
                out_valid_r <= 1'b1;
                result_r    <= base_res_s;
            end else if (state_r == ST_DONE) begin
                out_valid_r <= 1'b1;
                result_r    <= done_res_s;
            end else if (bus.out_ready) begin
                out_valid_r <= 1'b0;
            end
            // The slot is free at any accept, so the tag can be captured right away.
            if (accept_s) begin
                tag_out_r <= bus.tag_in;
            end
        end
    end
endmodule
